mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  M-stage memory controller for the 5-stage MIPS pipeline; replaces single-cycle mem_write decode.
//  Decodes lw/lh/lhu/lb/lbu/sw/sh/sb, builds byte enables and lane-replicated store data, extends load data.
//  Runs a req/ready handshake with a variable-latency data memory and stalls the pipeline while the access is in flight.
//  Bounded wait timeout reports a bus error.
// PARAMETERS
//  ADDR_W       32   data-memory byte-address width
//  HAS_SUBWORD  1    1: byte/half ops decoded; 0: only lw/sw are memory ops, others are non-memory
//  WAIT_W       8    width of wait counter
//  WAIT_LIMIT   255  BUSY cycles without dm_ready before bus error (< 2**WAIT_W)
// PORTS
//  clk        in   1       clock
//  reset      in   1       asynchronous reset, active-high
//  valid_M    in   1       instr_M holds a live instruction
//  instr_M    in   32      instruction in M stage
//  addr_M     in   ADDR_W  effective byte address (ALU result)
//  wdata_M    in   32      forwarded rt value
//  stall_M    out  1       freeze F/D/E/M registers
//  dm_req     out  1       memory request, held until dm_ready
//  dm_we      out  1       1 store, 0 load
//  dm_be      out  4       byte enables (bit i = bits 8i+7:8i)
//  dm_addr    out  ADDR_W  word-aligned address (addr_M[1:0] forced 0)
//  dm_wdata   out  32      lane-replicated store data
//  dm_ready   in   1       memory completes request this cycle
//  dm_rdata   in   32      read word, valid with dm_ready
//  ld_data    out  32      extended load result to M/W register
//  ld_valid   out  1       ld_data valid (DONE cycle, loads only)
//  exc_adel   out  1       misaligned load
//  exc_ades   out  1       misaligned store
//  exc_bus    out  1       timeout bus error
// BEHAVIOUR
//  Reset: state IDLE; dm_req, dm_we, dm_be, dm_addr, dm_wdata, ld_data, wait counter = 0; all flags 0.
//  Opcodes: lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, sb 101000, sh 101001, sw 101011.
//  Misalignment: lw/sw addr[1:0]!=0; lh/lhu/sh addr[0]!=0; byte never misaligned.
//  mem_op = valid_M & decoded memory opcode & !misaligned.
//  IDLE: exc_adel/exc_ades combinational (valid_M & misaligned op), no request, no stall.
//        mem_op: stall_M=1; register dm_*; clear counter; -> BUSY.
//  BUSY: dm_req=1, dm_* stable; stall_M=1; counter++.
//        dm_ready: capture extended dm_rdata into ld_data; -> DONE.
//        counter==WAIT_LIMIT & !dm_ready: drop dm_req, ld_data=0, set exc_bus; -> DONE.
//  DONE: stall_M=0 (pipeline advances this edge); ld_valid=1 for loads w/o bus error; exc_bus held this cycle only; -> IDLE.
//        valid_M/instr_M ignored in DONE (still the finished instr).
//  Minimum latency: 3 cycles (IDLE, BUSY with immediate ready, DONE); each extra ready-wait adds 1.
//  Byte enables: sb 4'b0001<<addr[1:0]; sh addr[1]?4'b1100:4'b0011; sw 4'b1111; loads 4'b1111.
//  Store data: sb {4{wdata[7:0]}}; sh {2{wdata[15:0]}}; sw wdata.
//  Load extend: lane = addr[1:0] (byte) or addr[1] (half); lb/lh sign-extend, lbu/lhu zero-extend.
//  dm_ready outside BUSY ignored. Async reset mid-BUSY: dm_req drops immediately, no completion reported.
//  Counter saturates; never wraps.
// STRUCTURE
//  Shared header mips_defs.vh: opcode localparams, FSM state encodings (IDLE/BUSY/DONE).
//  Sub-module mem_align (combinational): decode, misalign check, dm_be, store replication, load extend.
//  Top: FSM, wait counter, output registers.
// TESTING
//  sw addr 0x10, wdata 0xDEADBEEF, ready after 2 BUSY cycles -> be 4'hF, dm_addr 0x10, stall 4 cycles then release.
//  sb addr 0x13, wdata 0x000000A5 -> dm_be 4'b1000, dm_wdata 0xA5A5A5A5, dm_we 1.
//  lb addr 0x21, rdata 0x00008000 -> ld_data 0xFFFFFF80; lbu same -> 0x00000080; lhu addr 0x22, rdata 0x80010000 -> 0x00008001.
//  lw addr 0x06 -> exc_adel 1 same cycle, dm_req 0, stall_M 0; sh addr 0x05 -> exc_ades 1.
//  lw, dm_ready never asserted, WAIT_LIMIT 4 -> exc_bus 1 in DONE, ld_valid 0, ld_data 0.
//  reset pulsed mid-BUSY -> dm_req 0 before next edge, state IDLE, stall_M 0; HAS_SUBWORD=0: lb treated as non-memory.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: MIPS memory opcodes and M-stage access FSM states
package mem_access_unit_pkg;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: req/ready data-memory bus between the M stage and data memory
interface mem_access_unit_if #(parameter int ADDR_W = 32);
    logic              dm_req;
    logic              dm_we;
    logic [3:0]        dm_be;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic              dm_ready;
    logic [31:0]       dm_rdata;
    modport master(output dm_req, dm_we, dm_be, dm_addr, dm_wdata, input dm_ready, dm_rdata);
    modport slave(input dm_req, dm_we, dm_be, dm_addr, dm_wdata, output dm_ready, dm_rdata);
endinterface

// File: rtl/mem_access_unit_align.sv
// mem_align: opcode decode, misalignment, byte enables, store lane replication, load extension
module mem_align
    import mem_access_unit_pkg::*;
#(
    parameter bit HAS_SUBWORD = 1
) (
    input  logic [5:0]  op,
    input  logic [1:0]  lo,
    input  logic [31:0] wdata,
    input  logic [5:0]  ld_op,
    input  logic [1:0]  ld_lo,
    input  logic [31:0] rdata,
    output logic        is_mem,
    output logic        is_store,
    output logic        misaligned,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] ld_ext
);
    logic       is_word, is_half, is_byte;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    // decode the live instruction for issue, and extend read data for the registered one
    always_comb begin
        is_word    = op == OP_LW || op == OP_SW;
        is_half    = HAS_SUBWORD && (op == OP_LH || op == OP_LHU || op == OP_SH);
        is_byte    = HAS_SUBWORD && (op == OP_LB || op == OP_LBU || op == OP_SB);
        is_mem     = is_word || is_half || is_byte;
        is_store   = op == OP_SB || op == OP_SH || op == OP_SW;
        misaligned = is_word ? lo != 2'b00 : is_half && lo[0];
        be         = !is_store ? 4'hF : is_byte ? 4'b0001 << lo : is_half ? (lo[1] ? 4'b1100 : 4'b0011) : 4'hF;
        wdata_rep  = is_byte ? {4{wdata[7:0]}} : is_half ? {2{wdata[15:0]}} : wdata;
        ld_b       = rdata[{ld_lo, 3'b000} +: 8];
        ld_h       = ld_lo[1] ? rdata[31:16] : rdata[15:0];
        ld_ext     = ld_op == OP_LB  ? {{24{ld_b[7]}}, ld_b} :
                     ld_op == OP_LBU ? {24'b0, ld_b} :
                     ld_op == OP_LH  ? {{16{ld_h[15]}}, ld_h} :
                     ld_op == OP_LHU ? {16'b0, ld_h} : rdata;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage memory controller with req/ready handshake, stall and bus timeout
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter bit HAS_SUBWORD = 1,
    parameter int WAIT_W      = 8,
    parameter int WAIT_LIMIT  = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_M,
    input  logic [31:0]       instr_M,
    input  logic [ADDR_W-1:0] addr_M,
    input  logic [31:0]       wdata_M,
    output logic              stall_M,
    mem_access_unit_if.master dm,
    output logic [31:0]       ld_data,
    output logic              ld_valid,
    output logic              exc_adel,
    output logic              exc_ades,
    output logic              exc_bus
);
    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(WAIT_LIMIT);
    state_t            state, state_nxt;
    logic [WAIT_W-1:0] cnt;
    logic [5:0]        op_q;
    logic [1:0]        lo_q;
    logic              err_q;
    logic              is_mem, is_store, mis, mem_op, timeout;
    logic [3:0]        be;
    logic [31:0]       wrep, ld_ext;
    logic              unused_instr;
    assign unused_instr = ^instr_M[25:0];
    mem_align #(.HAS_SUBWORD(HAS_SUBWORD)) u_align (
        .op(instr_M[31:26]), .lo(addr_M[1:0]), .wdata(wdata_M),
        .ld_op(op_q), .ld_lo(lo_q), .rdata(dm.dm_rdata),
        .is_mem(is_mem), .is_store(is_store), .misaligned(mis),
        .be(be), .wdata_rep(wrep), .ld_ext(ld_ext)
    );
    assign mem_op  = valid_M && is_mem && !mis;
    // timeout is decided in the BUSY cycle whose counter reads WAIT_LIMIT; a same-cycle ready still wins
    assign timeout = !dm.dm_ready && cnt == LIMIT;
    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end
    // next-state: issue from IDLE, finish on ready or timeout, DONE lasts one cycle
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:  state_nxt = mem_op ? S_BUSY : S_IDLE;
            S_BUSY:  state_nxt = (dm.dm_ready || timeout) ? S_DONE : S_BUSY;
            default: state_nxt = S_IDLE;
        endcase
    end
    // outputs: request and stall follow state, exceptions only on a fresh IDLE instruction
    always_comb begin
        dm.dm_req = state == S_BUSY;
        stall_M   = state == S_BUSY || (state == S_IDLE && mem_op);
        ld_valid  = state == S_DONE && !dm.dm_we && !err_q;
        exc_bus   = state == S_DONE && err_q;
        exc_adel  = state == S_IDLE && valid_M && is_mem && mis && !is_store;
        exc_ades  = state == S_IDLE && valid_M && is_mem && mis && is_store;
    end
    // bus registers latched at issue, wait counter and load result during BUSY
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dm.dm_we    <= 1'b0;
            dm.dm_be    <= '0;
            dm.dm_addr  <= '0;
            dm.dm_wdata <= '0;
            op_q        <= '0;
            lo_q        <= '0;
            cnt         <= '0;
            err_q       <= 1'b0;
            ld_data     <= '0;
        end else if (state == S_IDLE && mem_op) begin
            dm.dm_we    <= is_store;
            dm.dm_be    <= be;
            dm.dm_addr  <= {addr_M[ADDR_W-1:2], 2'b00};
            dm.dm_wdata <= wrep;
            op_q        <= instr_M[31:26];
            lo_q        <= addr_M[1:0];
            cnt         <= '0;
            err_q       <= 1'b0;
        end else if (state == S_BUSY) begin
            cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
            if (dm.dm_ready) ld_data <= ld_ext;
            else if (timeout) begin
                ld_data <= '0;
                err_q   <= 1'b1;
            end
        end
    end
endmodule
